// File: rtl/mips_pkg.sv
// rtl/mips_pkg.sv - opcodes, functs, FSM states and ALU ops for the multi-cycle MIPS core
package mips_pkg;

    localparam int NUM_REGS = 32;
    localparam int REG_AW   = 5;

    localparam logic [5:0] OP_RTYPE = 6'h00;
    localparam logic [5:0] OP_LW    = 6'h23;
    localparam logic [5:0] OP_SW    = 6'h2B;
    localparam logic [5:0] OP_BEQ   = 6'h04;
    localparam logic [5:0] OP_ADDI  = 6'h08;
    localparam logic [5:0] OP_J     = 6'h02;

    localparam logic [5:0] FN_ADD = 6'h20;
    localparam logic [5:0] FN_SUB = 6'h22;
    localparam logic [5:0] FN_AND = 6'h24;
    localparam logic [5:0] FN_OR  = 6'h25;
    localparam logic [5:0] FN_SLT = 6'h2A;

    typedef enum logic [2:0] {
        FETCH,
        DECODE,
        EXEC,
        MEM,
        WB,
        HALT
    } state_t;

    typedef enum logic [2:0] {
        ALU_ADD,
        ALU_SUB,
        ALU_AND,
        ALU_OR,
        ALU_SLT
    } alu_op_t;

    // Anything outside the supported opcode/funct set halts the core.
    function automatic logic is_legal(input logic [5:0] op, input logic [5:0] funct);
        case (op)
            OP_RTYPE: return (funct == FN_ADD) || (funct == FN_SUB) || (funct == FN_AND) ||
                             (funct == FN_OR)  || (funct == FN_SLT);
            OP_LW, OP_SW, OP_BEQ, OP_ADDI, OP_J: return 1'b1;
            default: return 1'b0;
        endcase
    endfunction

endpackage

// File: rtl/mips_regfile.sv
// rtl/mips_regfile.sv - 32-entry register file, two async reads, one sync write, $0 tied to zero
module mips_regfile
    import mips_pkg::*;
#(
    parameter int DATA_W = 32
) (
    input  logic              clock,
    input  logic              reset,
    input  logic [REG_AW-1:0] rd_addr_a,
    output logic [DATA_W-1:0] rd_data_a,
    input  logic [REG_AW-1:0] rd_addr_b,
    output logic [DATA_W-1:0] rd_data_b,
    input  logic              wr_en,
    input  logic [REG_AW-1:0] wr_addr,
    input  logic [DATA_W-1:0] wr_data
);

    logic [NUM_REGS-1:0][DATA_W-1:0] regs_q;
    logic [NUM_REGS-1:0][DATA_W-1:0] regs_d;

    assign rd_data_a = regs_q[rd_addr_a];
    assign rd_data_b = regs_q[rd_addr_b];

    // Next register contents: apply the write port, then force $0 back to zero.
    always_comb begin
        regs_d = regs_q;
        if (wr_en) begin
            regs_d[wr_addr] = wr_data;
        end
        regs_d[0] = '0;
    end

    // Register storage with synchronous active-low clear.
    always_ff @(posedge clock) begin
        if (!reset) begin
            regs_q <= '0;
        end else begin
            regs_q <= regs_d;
        end
    end

endmodule

// File: rtl/mips_multicycle_cpu.sv
// rtl/mips_multicycle_cpu.sv - multi-cycle MIPS core with a shared req/ready word-addressed memory port
module mips_multicycle_cpu #(
    parameter int DATA_W = 32,
    parameter int ADDR_W = 16
) (
    input  logic              clock,
    input  logic              reset,
    output logic              mem_req,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic [DATA_W-1:0] mem_rdata,
    input  logic              mem_ready,
    output logic              halted,
    output logic              retire,
    output logic [ADDR_W-1:0] pc_dbg
);

    import mips_pkg::*;

    state_t            state_q, state_d;
    logic [ADDR_W-1:0] pc_q, pc_d;
    logic [31:0]       ir_q, ir_d;
    logic [DATA_W-1:0] a_q, a_d;
    logic [DATA_W-1:0] b_q, b_d;
    logic [DATA_W-1:0] alu_out_q, alu_out_d;
    logic [DATA_W-1:0] mdr_q, mdr_d;

    logic [5:0]        op;
    logic [5:0]        funct;
    logic [4:0]        rs;
    logic [4:0]        rt;
    logic [4:0]        rd;
    logic [DATA_W-1:0] sext_imm;
    logic [ADDR_W-1:0] branch_target;
    logic [DATA_W-1:0] rf_rd_a;
    logic [DATA_W-1:0] rf_rd_b;
    logic              rf_we;
    logic [4:0]        rf_wa;
    logic [DATA_W-1:0] rf_wd;
    alu_op_t           alu_op;
    logic [DATA_W-1:0] alu_b;
    logic [DATA_W-1:0] alu_result;
    logic              retire_c;

    assign op            = ir_q[31:26];
    assign rs            = ir_q[25:21];
    assign rt            = ir_q[20:16];
    assign rd            = ir_q[15:11];
    assign funct         = ir_q[5:0];
    assign sext_imm      = {{(DATA_W-16){ir_q[15]}}, ir_q[15:0]};
    // pc_q already holds PC+1 once the fetch has completed.
    assign branch_target = pc_q + sext_imm[ADDR_W-1:0];

    assign rf_we = (state_q == WB);
    assign rf_wa = (op == OP_RTYPE) ? rd : rt;
    assign rf_wd = (op == OP_LW) ? mdr_q : alu_out_q;

    mips_regfile #(
        .DATA_W(DATA_W)
    ) u_regfile (
        .clock    (clock),
        .reset    (reset),
        .rd_addr_a(rs),
        .rd_data_a(rf_rd_a),
        .rd_addr_b(rt),
        .rd_data_b(rf_rd_b),
        .wr_en    (rf_we),
        .wr_addr  (rf_wa),
        .wr_data  (rf_wd)
    );

    // ALU operation select: R-type follows funct, everything else adds.
    always_comb begin
        alu_op = ALU_ADD;
        if (op == OP_RTYPE) begin
            case (funct)
                FN_SUB:  alu_op = ALU_SUB;
                FN_AND:  alu_op = ALU_AND;
                FN_OR:   alu_op = ALU_OR;
                FN_SLT:  alu_op = ALU_SLT;
                default: alu_op = ALU_ADD;
            endcase
        end
    end

    assign alu_b = (op == OP_RTYPE) ? b_q : sext_imm;

    // ALU datapath, modulo 2^DATA_W; slt compares as signed.
    always_comb begin
        alu_result = '0;
        case (alu_op)
            ALU_ADD: alu_result = a_q + alu_b;
            ALU_SUB: alu_result = a_q - alu_b;
            ALU_AND: alu_result = a_q & alu_b;
            ALU_OR:  alu_result = a_q | alu_b;
            ALU_SLT: alu_result = {{(DATA_W-1){1'b0}}, ($signed(a_q) < $signed(alu_b))};
            default: alu_result = '0;
        endcase
    end

    // FSM next state and datapath register updates.
    always_comb begin
        state_d   = state_q;
        pc_d      = pc_q;
        ir_d      = ir_q;
        a_d       = a_q;
        b_d       = b_q;
        alu_out_d = alu_out_q;
        mdr_d     = mdr_q;
        case (state_q)
            FETCH: begin
                if (mem_ready) begin
                    ir_d    = mem_rdata[31:0];
                    pc_d    = pc_q + ADDR_W'(1);
                    state_d = DECODE;
                end
            end
            DECODE: begin
                a_d       = rf_rd_a;
                b_d       = rf_rd_b;
                alu_out_d = {{(DATA_W-ADDR_W){1'b0}}, branch_target};
                if (!is_legal(op, funct)) begin
                    state_d = HALT;
                end else if (op == OP_J) begin
                    pc_d    = ir_q[ADDR_W-1:0];
                    state_d = FETCH;
                end else begin
                    state_d = EXEC;
                end
            end
            EXEC: begin
                if (op == OP_BEQ) begin
                    if (a_q == b_q) begin
                        pc_d = alu_out_q[ADDR_W-1:0];
                    end
                    state_d = FETCH;
                end else begin
                    alu_out_d = alu_result;
                    state_d   = ((op == OP_RTYPE) || (op == OP_ADDI)) ? WB : MEM;
                end
            end
            MEM: begin
                if (mem_ready) begin
                    if (op == OP_SW) begin
                        state_d = FETCH;
                    end else begin
                        mdr_d   = mem_rdata;
                        state_d = WB;
                    end
                end
            end
            WB: begin
                state_d = FETCH;
            end
            HALT: begin
                state_d = HALT;
            end
            default: begin
                state_d = FETCH;
            end
        endcase
    end

    // State and datapath registers; reset abandons any in-flight access.
    always_ff @(posedge clock) begin
        if (!reset) begin
            state_q   <= FETCH;
            pc_q      <= '0;
            ir_q      <= '0;
            a_q       <= '0;
            b_q       <= '0;
            alu_out_q <= '0;
            mdr_q     <= '0;
        end else begin
            state_q   <= state_d;
            pc_q      <= pc_d;
            ir_q      <= ir_d;
            a_q       <= a_d;
            b_q       <= b_d;
            alu_out_q <= alu_out_d;
            mdr_q     <= mdr_d;
        end
    end

    // Retire marks the cycle whose edge returns the FSM to FETCH.
    always_comb begin
        retire_c = 1'b0;
        case (state_q)
            DECODE:  retire_c = (op == OP_J);
            EXEC:    retire_c = (op == OP_BEQ);
            MEM:     retire_c = (op == OP_SW) && mem_ready;
            WB:      retire_c = 1'b1;
            default: retire_c = 1'b0;
        endcase
    end

    assign mem_req   = (state_q == FETCH) || (state_q == MEM);
    assign mem_we    = (state_q == MEM) && (op == OP_SW);
    assign mem_addr  = (state_q == MEM) ? alu_out_q[ADDR_W-1:0] : pc_q;
    assign mem_wdata = b_q;
    assign halted    = (state_q == HALT) && reset;
    assign retire    = retire_c && reset;
    assign pc_dbg    = pc_q;

endmodule
